booth_mul_arbiter: RTL and testbench
====================================

# booth_mul_arbiter

Two-requester front end for the pipelined 11×11 Booth significand multiplier. It arbitrates round-robin between two valid/ready requesters and drives the multiplier's operand inputs. It tracks each in-flight operation with a latency-matched tag pipeline and steers every product into a per-requester response FIFO. Because the multiplier pipeline cannot stall, the block uses credits so that an issued operation always has a FIFO slot waiting for its result.

## Interface
- FIFO_DEPTH, 4: entries per response FIFO; power of two, ≥2; also the credit limit per requester.
- MUL_LAT, 8 (package constant): edges from operand capture by the multiplier to the product being valid plus one.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset. One clock; reset is synchronous and active-high. The multiplier's active-low reset is driven from ~RST at integration.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted this cycle (one-hot or zero).
- req_a / req_b  in  20  10-bit fractions, {r1, r0}.
- req_ah / req_bh  in  2  hidden bits, {r1, r0}.
- rsp_valid  out  2  FIFO i non-empty.
- rsp_ready  in  2  pop FIFO i.
- rsp_data  out  48  FIFO i head, {r1[23:0], r0[23:0]}.
- mul_a / mul_b  out  10  multiplier operands.
- mul_azero / mul_bzero  out  1  multiplier hidden-bit inputs.
- mul_s  in  24  multiplier product.
- busy  out  1  any tag valid or any FIFO non-empty.

## Operation
- Credit counter cnt[i], 0..FIFO_DEPTH, equals FIFO occupancy plus in-flight ops for requester i.
  - +1 on issue for i, −1 on pop of i. Issue and pop in the same cycle leave it unchanged.
- eligible[i] = req_valid[i] & (cnt[i] < FIFO_DEPTH).
- Grant rule:
  - One eligible requester: grant it.
  - Both eligible: grant the requester that was not granted last.
  - Last-grant pointer updates only on a grant; its reset value is 1, so requester 0 wins first.
- req_ready[i] = grant[i]. It may depend on req_valid. It is forced 0 while RST=1.
- Multiplier operand drive:
  - With a grant: mul_* carry the granted requester's operands combinationally.
  - Without a grant: mul_* = 0.
- Tag pipeline of MUL_LAT stages, each {valid, id}. Stage 0 loads {grant_any, granted id} every edge; other stages shift every edge.
- When stage MUL_LAT−1 is valid, mul_s is written into FIFO[id] at the next edge.
- FIFOs are first-word-fall-through, so rsp_data[i] is the head whenever rsp_valid[i]=1.
- Results for each requester return in issue order.
- Overflow is impossible by construction. A write to a full FIFO is an assertion failure.

## Timing
- Handshake at edge k means the multiplier captures the operands at edge k, mul_s is valid after edge k+7, and the FIFO writes at edge k+8.
- rsp_valid rises after edge k+8, i.e. 8 cycles of latency to the response.
- Throughput is one issue per cycle across both requesters.
- With rsp_ready held high, each requester sustains one issue per cycle when alone, or one every 2 cycles when contending.
- Credit boundaries:
  - When cnt[i]=FIFO_DEPTH, req_ready[i]=0 until the cycle after a pop.
  - A pop at edge e makes requester i eligible in the cycle following e.
- Reset values: tags invalid, FIFOs empty, cnt=0, pointer=1, rsp_valid=0, req_ready=0, mul_*=0, busy=0.
- Reset mid-operation:
  - All in-flight ops are discarded.
  - No rsp_valid appears in the cycles after reset deasserts until a new issue completes.

## Configuration
- BOOTH_ARB_FIXED_PRIO_EN:
  - Defined: requester 0 wins every conflict, and the last-grant pointer is removed.
  - Undefined: round-robin as above.
- Credit behaviour is identical in both modes.

## Structure
- Package booth_mul_pkg:
  - MUL_LAT = 8
  - FRAC_W = 10, PROD_W = 24
  - tag typedef {logic valid; logic id;}
- Sub-module booth_rsp_fifo:
  - Parameters PROD_W and FIFO_DEPTH.
  - First-word-fall-through; ports push, push_data, pop, head, empty, full.
  - Instantiated twice.
- Arbiter, credit counters and tag pipeline stay in the top module.

## Test plan
The bench uses a behavioural multiplier stub with 8-edge latency: mul_s = {2'b0, {ah,a} × {bh,b}}.
- Single op: req0 a=10'h200, ah=1, b=10'h000, bh=1 issued at edge k, rsp_ready=1 → rsp_valid[0] after edge k+8, rsp_data[23:0]=24'h180000, busy falls one cycle after the pop.
- Contention: both requesters valid every cycle, rsp_ready=2'b11 → grants alternate 0,1,0,1 starting with 0; each requester's results come back in order with correct products.
- Backpressure: rsp_ready[0]=0 with req0 continuous → exactly 4 req0 issues, then req_ready[0]=0. Requester 1 keeps one issue per cycle once req0 is blocked. Raising rsp_ready[0] for one cycle → req0 re-issues exactly once, in the following cycle.
- Simultaneous issue and pop at cnt[1]=3 → cnt stays 3 and req_ready[1] stays available.
- Reset mid-flight: RST high for one cycle with 5 ops in flight → no rsp_valid for 20 cycles, busy=0. A new req1 op then returns its correct product 8 cycles after issue.
- With BOOTH_ARB_FIXED_PRIO_EN defined, both requesters valid → req0 is granted every cycle until its credits are exhausted, then req1 is granted.

Source files
------------

// File: rtl/booth_mul_pkg.sv
// booth_mul_pkg: shared constants and the in-flight tag type for the
// Booth multiplier front end.
package booth_mul_pkg;
    localparam int MUL_LAT = 8;   // operand capture edge to FIFO write edge
    localparam int FRAC_W  = 10;
    localparam int PROD_W  = 24;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;
endpackage

// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: requester, response and multiplier-side signals of
// booth_mul_arbiter. Lane i of every 2-wide field belongs to requester i.
interface booth_mul_arbiter_if;
    import booth_mul_pkg::*;

    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [1:0][FRAC_W-1:0]  req_a;
    logic [1:0][FRAC_W-1:0]  req_b;
    logic [1:0]              req_ah;
    logic [1:0]              req_bh;
    logic [1:0]              rsp_valid;
    logic [1:0]              rsp_ready;
    logic [1:0][PROD_W-1:0]  rsp_data;
    logic [FRAC_W-1:0]       mul_a;
    logic [FRAC_W-1:0]       mul_b;
    logic                    mul_azero;
    logic                    mul_bzero;
    logic [PROD_W-1:0]       mul_s;
    logic                    busy;

    modport master (
        output req_valid, req_a, req_b, req_ah, req_bh, rsp_ready, mul_s,
        input  req_ready, rsp_valid, rsp_data, mul_a, mul_b, mul_azero, mul_bzero, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ah, req_bh, rsp_ready, mul_s,
        output req_ready, rsp_valid, rsp_data, mul_a, mul_b, mul_azero, mul_bzero, busy
    );
endinterface

// File: rtl/booth_rsp_fifo.sv
// booth_rsp_fifo: first-word-fall-through response FIFO. head is valid
// whenever empty is low. Pointers carry one wrap bit to tell full from empty.
module booth_rsp_fifo #(
    parameter int PROD_W     = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [PROD_W-1:0] push_data,
    input  logic              pop,
    output logic [PROD_W-1:0] head,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PROD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wp, r_rp;

    assign empty = (r_wp == r_rp);
    assign full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign head  = r_mem[r_rp[AW-1:0]];

    // Pointer update; a pop on an empty FIFO is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (push)          r_wp <= r_wp + 1'b1;
            if (pop && !empty) r_rp <= r_rp + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wp[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: two-requester front end for the pipelined 11x11 Booth
// multiplier. Round-robin grant, credit counters that reserve a FIFO slot per
// issued op, a tag pipeline matched to MUL_LAT, and two response FIFOs.
// Macro BOOTH_ARB_FIXED_PRIO_EN: requester 0 wins every conflict and the
// last-grant pointer is removed.
module booth_mul_arbiter
    import booth_mul_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    booth_mul_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0][CNT_W-1:0]  r_cnt;
    tag_t [MUL_LAT-1:0]     r_tag;
    logic [1:0]             w_elig, w_grant, w_push, w_pop, w_empty, w_full;
    logic [1:0][PROD_W-1:0] w_head;
    logic                   w_gany, w_gid, w_tag_any;
    tag_t                   w_tail;

    // A request is eligible only while a FIFO slot can still be reserved.
    always_comb begin
        w_elig = 2'b00;
        for (int i = 0; i < 2; i++)
            w_elig[i] = bus.req_valid[i] && (r_cnt[i] < CNT_W'(FIFO_DEPTH));
    end

`ifdef BOOTH_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 first; nothing granted during reset.
    always_comb begin
        w_grant = 2'b00;
        if (!RST) begin
            if (w_elig[0])      w_grant = 2'b01;
            else if (w_elig[1]) w_grant = 2'b10;
        end
    end
`else
    logic r_last;

    // Round-robin: on conflict grant the requester not granted last.
    always_comb begin
        w_grant = 2'b00;
        if (!RST) begin
            if (&w_elig) w_grant = r_last ? 2'b01 : 2'b10;
            else         w_grant = w_elig;
        end
    end

    // Last-grant pointer moves only on a grant; reset to 1 so requester 0 wins first.
    always_ff @(posedge CLK) begin
        if (RST)         r_last <= 1'b1;
        else if (w_gany) r_last <= w_gid;
    end
`endif

    assign w_gany        = |w_grant;
    assign w_gid         = w_grant[1];
    assign bus.req_ready = w_grant;

    // Operand steering to the multiplier; zeros when idle.
    always_comb begin
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        bus.mul_azero = 1'b0;
        bus.mul_bzero = 1'b0;
        if (w_gany) begin
            bus.mul_a     = bus.req_a[w_gid];
            bus.mul_b     = bus.req_b[w_gid];
            bus.mul_azero = bus.req_ah[w_gid];
            bus.mul_bzero = bus.req_bh[w_gid];
        end
    end

    // Tag pipeline tracks each issued op until its product leaves the multiplier.
    always_ff @(posedge CLK) begin
        if (RST) r_tag <= '0;
        else     r_tag <= {r_tag[MUL_LAT-2:0], tag_t'{valid: w_gany, id: w_gid}};
    end

    assign w_tail = r_tag[MUL_LAT-1];

    // Credits = FIFO occupancy + in-flight ops; issue and pop together cancel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_grant[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                else if (!w_grant[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_rsp
        assign w_push[i] = w_tail.valid && (w_tail.id == 1'(i));
        assign w_pop[i]  = bus.rsp_ready[i] && !w_empty[i];

        booth_rsp_fifo #(
            .PROD_W     (PROD_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (CLK),
            .rst       (RST),
            .push      (w_push[i]),
            .push_data (bus.mul_s),
            .pop       (w_pop[i]),
            .head      (w_head[i]),
            .empty     (w_empty[i]),
            .full      (w_full[i])
        );
    end

    // Any tag in flight keeps the block busy.
    always_comb begin
        w_tag_any = 1'b0;
        for (int j = 0; j < MUL_LAT; j++) w_tag_any = w_tag_any | r_tag[j].valid;
    end

    assign bus.rsp_valid = ~w_empty;
    assign bus.rsp_data  = w_head;
    assign bus.busy      = w_tag_any | ~(&w_empty);

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(|(w_push & w_full)));
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: randomized and directed stimulus against a queue-based
// reference model of the arbiter, credits and response ordering. A behavioural
// 8-edge multiplier stub closes the loop on mul_* / mul_s.
module tb_booth_mul_arbiter;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_mul_arbiter_if bus ();

    booth_mul_arbiter #(.FIFO_DEPTH(FD)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Multiplier stub: operands captured at edge k, product visible after edge k+7.
    logic [23:0] stub [8];
    always @(posedge clk) begin
        stub[0] <= {13'b0, bus.mul_azero, bus.mul_a} * {13'b0, bus.mul_bzero, bus.mul_b};
        for (int s = 1; s < 8; s++) stub[s] <= stub[s-1];
    end
    assign bus.mul_s = stub[7];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] prod(input logic ah, input logic [9:0] a,
                                         input logic bh, input logic [9:0] b);
        int unsigned x, y;
        x = {ah, a};
        y = {bh, b};
        return 24'(x * y);
    endfunction

    // Reference model: per-requester queue of issued-but-not-popped ops.
    typedef struct {
        logic [23:0] p;
        int unsigned k;   // edge at which the op was issued
    } op_t;

    op_t         q0[$], q1[$];
    bit          m_last = 1'b1;
    int unsigned cyc = 0;
    int          iss0 = 0, iss1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        @(posedge clk);
        forever begin
            logic [1:0]  el, eg, ev;
            logic [21:0] eop;
            int          sz0, sz1;
            @(negedge clk);
            sz0 = q0.size();
            sz1 = q1.size();
            el  = {bus.req_valid[1] && sz1 < FD, bus.req_valid[0] && sz0 < FD};
            if (rst) eg = 2'b00;
`ifdef BOOTH_ARB_FIXED_PRIO_EN
            else eg = el[0] ? 2'b01 : (el[1] ? 2'b10 : 2'b00);
`else
            else if (el == 2'b11) eg = m_last ? 2'b01 : 2'b10;
            else eg = el;
`endif
            chk("req_ready", bus.req_ready, eg);
            eop = eg[0] ? {bus.req_ah[0], bus.req_a[0], bus.req_bh[0], bus.req_b[0]} :
                  eg[1] ? {bus.req_ah[1], bus.req_a[1], bus.req_bh[1], bus.req_b[1]} : 22'h0;
            chk("mul_ops", {bus.mul_azero, bus.mul_a, bus.mul_bzero, bus.mul_b}, eop);
            ev[0] = (sz0 > 0) && (q0[0].k + 8 <= cyc);
            ev[1] = (sz1 > 0) && (q1[0].k + 8 <= cyc);
            chk("rsp_valid", bus.rsp_valid, ev);
            if (ev[0]) chk("rsp_data0", bus.rsp_data[0], q0[0].p);
            if (ev[1]) chk("rsp_data1", bus.rsp_data[1], q1[0].p);
            chk("busy", bus.busy, (sz0 + sz1) > 0);
            // Advance the model across the coming edge.
            if (rst) begin
                q0.delete();
                q1.delete();
                m_last = 1'b1;
            end else begin
                if (ev[0] && bus.rsp_ready[0]) void'(q0.pop_front());
                if (ev[1] && bus.rsp_ready[1]) void'(q1.pop_front());
                if (eg[0]) begin
                    q0.push_back('{p: prod(bus.req_ah[0], bus.req_a[0], bus.req_bh[0], bus.req_b[0]), k: cyc + 1});
                    iss0++;
                end
                if (eg[1]) begin
                    q1.push_back('{p: prod(bus.req_ah[1], bus.req_a[1], bus.req_bh[1], bus.req_b[1]), k: cyc + 1});
                    iss1++;
                end
                if (eg != 2'b00) m_last = eg[1];
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] r);
        bus.req_valid = v;
        bus.rsp_ready = r;
        bus.req_a     = 20'($urandom);
        bus.req_b     = 20'($urandom);
        bus.req_ah    = 2'($urandom);
        bus.req_bh    = 2'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            drive(2'b00, 2'b11);
            tick();
        end
    endtask

    // Wait for rsp_valid[id] with a bounded budget; lat=0 means it never came.
    task automatic wait_rsp(input int id, output int lat);
        lat = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (bus.rsp_valid[id]) begin
                lat = j;
                break;
            end
        end
    endtask

    initial begin
        int          lat, s0, s1;
        logic [23:0] exp_p;

        drive(2'b00, 2'b00);
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mul", {bus.mul_azero, bus.mul_a, bus.mul_bzero, bus.mul_b}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single op: 1.5 * 1.0 in 11-bit fixed point.
        bus.req_valid = 2'b01;
        bus.req_a     = 20'h00200;
        bus.req_ah    = 2'b01;
        bus.req_b     = 20'h00000;
        bus.req_bh    = 2'b01;
        bus.rsp_ready = 2'b11;
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(0, lat);
        chk("single_lat", lat, 9);
        chk("single_data", bus.rsp_data[0], 24'h180000);
        @(negedge clk);
        chk("single_busy", bus.busy, 0);
        tick();

        // Contention with both requesters always valid.
        for (int n = 0; n < 40; n++) begin
            drive(2'b11, 2'b11);
            tick();
        end
        drain();

        // Backpressure on requester 0.
        s0 = iss0;
        for (int n = 0; n < 12; n++) begin
            drive(2'b01, 2'b10);
            tick();
        end
        chk("bp_issue0", iss0 - s0, 4);
        s0 = iss0;
        s1 = iss1;
        for (int n = 0; n < 10; n++) begin
            drive(2'b11, 2'b10);
            tick();
        end
        chk("bp_blocked0", iss0 - s0, 0);
        chk("bp_run1", iss1 != s1, 1);
        drive(2'b11, 2'b11);
        tick();
        drive(2'b11, 2'b10);
        s0 = iss0;
        @(negedge clk);
        chk("bp_rel_ready", bus.req_ready[0], 1);
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            drive(2'b11, 2'b10);
        end
        chk("bp_rel_once", iss0 - s0, 1);
        drain();

        // Issue and pop in the same cycle with three credits used.
        for (int n = 0; n < 3; n++) begin
            drive(2'b10, 2'b00);
            tick();
        end
        for (int n = 0; n < 12; n++) begin
            drive(2'b00, 2'b00);
            tick();
        end
        drive(2'b10, 2'b10);
        @(negedge clk);
        chk("ip_ready", bus.req_ready[1], 1);
        tick();
        drive(2'b10, 2'b00);
        @(negedge clk);
        chk("ip_hold", bus.req_ready[1], 1);
        tick();
        drive(2'b10, 2'b00);
        @(negedge clk);
        chk("ip_full", bus.req_ready[1], 0);
        tick();
        drain();

        // Reset with five ops in flight.
        for (int n = 0; n < 5; n++) begin
            drive(2'b11, 2'b11);
            tick();
        end
        drive(2'b00, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("rstf_rsp_valid", bus.rsp_valid, 0);
            chk("rstf_busy", bus.busy, 0);
        end
        tick();
        drive(2'b10, 2'b11);
        exp_p = prod(bus.req_ah[1], bus.req_a[1], bus.req_bh[1], bus.req_b[1]);
        tick();
        bus.req_valid = 2'b00;
        wait_rsp(1, lat);
        chk("rstf_lat", lat, 9);
        chk("rstf_data", bus.rsp_data[1], exp_p);
        tick();
        drain();

        // Random traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            drive(2'($urandom), 2'($urandom));
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        drain();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
